// File: rtl/aes_pkg.sv
// Shared AES constants, tables and GF(2^8) helpers
// for the iterative inverse cipher core.
package aes_pkg;

  localparam int RND_SIZE = 128;
  localparam int NUM_RND  = 10;
  localparam int CNT_SIZE = 4;

  typedef enum logic [1:0] {
    IDLE,
    KEXP,
    RND,
    DONE
  } fsm_e;

  // Byte x sits at bits {~x,3'b000} +: 8 (entry 0 is the MSB byte).
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] ISBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [7:0] RCON [1:NUM_RND] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(
    input logic [7:0] x
  );
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(
    input logic [7:0] x
  );
    return ISBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [3:0] k
  );
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round; lst_rnd
// skips InvMixColumns for the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [RND_SIZE-1:0] state,
  input  logic [RND_SIZE-1:0] rnd_key,
  input  logic                lst_rnd,
  output logic [RND_SIZE-1:0] nxt_state
);

  logic [RND_SIZE-1:0] sub;
  logic [RND_SIZE-1:0] ark;
  logic [RND_SIZE-1:0] imc;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // row r rotates right by r: out[r][c] = in[r][c-r]
      localparam int SRC = 4 * ((c + 4 - r) % 4) + r;
      localparam int DST = 4 * c + r;
      assign sub[127-8*DST -: 8] =
        inv_sbox(state[127-8*SRC -: 8]);
    end

    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = ark[127-32*c -: 32];

    assign imc[127-32*c -: 32] = {
      gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^
      gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
      gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^
      gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
      gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^
      gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
      gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^
      gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)
    };
  end

  assign ark       = sub ^ rnd_key;
  assign nxt_state = lst_rnd ? ark : imc;

endmodule

// File: rtl/aes_key_gen.sv
// One step of the AES-128 key schedule:
// derives round key n from round key n-1.
module aes_key_gen
  import aes_pkg::*;
(
  input  logic [RND_SIZE-1:0] key,
  input  logic [7:0]          rcon,
  output logic [RND_SIZE-1:0] nxt_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n0, n1, n2, n3;
  logic [31:0] tmp;

  assign {w0, w1, w2, w3} = key;

  // SubWord(RotWord(w3)) with Rcon folded into the top byte
  assign tmp = {
    sbox(w3[23:16]) ^ rcon,
    sbox(w3[15:8]),
    sbox(w3[7:0]),
    sbox(w3[31:24])
  };

  assign n0 = w0 ^ tmp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign nxt_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 decryption core: expands the
// key once, then runs one inverse round per clock.
module aes_inv_cipher_core
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_key_vld,
  output logic                o_key_rdy,
  input  logic [RND_SIZE-1:0] i_key,
  output logic                o_key_ok,
  input  logic                i_ct_vld,
  output logic                o_ct_rdy,
  input  logic [RND_SIZE-1:0] i_ct,
  output logic                o_pt_vld,
  input  logic                i_pt_rdy,
  output logic [RND_SIZE-1:0] o_pt
);

  localparam logic [CNT_SIZE-1:0] CNT_MAX =
    CNT_SIZE'(NUM_RND);

  fsm_e                st_q, st_d;
  logic [CNT_SIZE-1:0] cnt_q, cnt_d;
  logic [RND_SIZE-1:0] blk_q, blk_d;
  logic [RND_SIZE-1:0] pt_q, pt_d;
  logic                key_ok_q, key_ok_d;
  logic                pt_vld_q, pt_vld_d;

  logic [RND_SIZE-1:0] rk_q [0:NUM_RND];
  logic                rk_we;
  logic [CNT_SIZE-1:0] rk_wa;
  logic [RND_SIZE-1:0] rk_wd;

  logic [RND_SIZE-1:0] kg_out;
  logic [RND_SIZE-1:0] rnd_out;
  logic                key_hs;
  logic                ct_hs;

  assign o_key_rdy = (st_q == IDLE);
  assign o_ct_rdy  = o_key_rdy & key_ok_q & ~i_key_vld;
  assign key_hs    = i_key_vld & o_key_rdy;
  assign ct_hs     = i_ct_vld & o_ct_rdy;

  assign o_key_ok  = key_ok_q;
  assign o_pt_vld  = pt_vld_q;
  assign o_pt      = pt_q;

  aes_key_gen u_key_gen (
    .key     (rk_q[cnt_q - 4'd1]),
    .rcon    (RCON[cnt_q]),
    .nxt_key (kg_out)
  );

  aes_inv_round u_inv_round (
    .state     (blk_q),
    .rnd_key   (rk_q[cnt_q]),
    .lst_rnd   (cnt_q == '0),
    .nxt_state (rnd_out)
  );

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    blk_d    = blk_q;
    pt_d     = pt_q;
    key_ok_d = key_ok_q;
    pt_vld_d = pt_vld_q;
    rk_we    = 1'b0;
    rk_wa    = cnt_q;
    rk_wd    = kg_out;
    unique case (st_q)
      IDLE: begin
        if (key_hs) begin
          rk_we    = 1'b1;
          rk_wa    = '0;
          rk_wd    = i_key;
          key_ok_d = 1'b0;
          cnt_d    = CNT_SIZE'(1);
          st_d     = KEXP;
        end else if (ct_hs) begin
          blk_d = i_ct ^ rk_q[NUM_RND];
          cnt_d = CNT_MAX - CNT_SIZE'(1);
          st_d  = RND;
        end
      end
      KEXP: begin
        rk_we = 1'b1;
        if (cnt_q == CNT_MAX) begin
          key_ok_d = 1'b1;
          cnt_d    = '0;
          st_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_SIZE'(1);
        end
      end
      RND: begin
        blk_d = rnd_out;
        if (cnt_q == '0) begin
          pt_d     = rnd_out;
          pt_vld_d = 1'b1;
          st_d     = DONE;
        end else begin
          cnt_d = cnt_q - CNT_SIZE'(1);
        end
      end
      DONE: begin
        if (i_pt_rdy) begin
          pt_vld_d = 1'b0;
          st_d     = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= IDLE;
      cnt_q    <= '0;
      blk_q    <= '0;
      pt_q     <= '0;
      key_ok_q <= 1'b0;
      pt_vld_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      blk_q    <= blk_d;
      pt_q     <= pt_d;
      key_ok_q <= key_ok_d;
      pt_vld_q <= pt_vld_d;
    end
  end

  // Contents need no reset: key_ok gates every use.
  always_ff @(posedge clk) begin
    if (rk_we) rk_q[rk_wa] <= rk_wd;
  end

  cnt_bound_a: assert property (
    @(posedge clk) disable iff (rst)
    cnt_q <= CNT_MAX
  );

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Bench for aes_inv_cipher_core: known-answer table,
// corner sequences, random blocks vs a byte-level model.
module tb_aes_inv_cipher_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_key_vld = 1'b0;
  logic         o_key_rdy;
  logic [127:0] i_key = '0;
  logic         o_key_ok;
  logic         i_ct_vld = 1'b0;
  logic         o_ct_rdy;
  logic [127:0] i_ct = '0;
  logic         o_pt_vld;
  logic         i_pt_rdy = 1'b0;
  logic [127:0] o_pt;

  always #5 clk = ~clk;

  aes_inv_cipher_core dut (
    .clk       (clk),
    .rst       (rst),
    .i_key_vld (i_key_vld),
    .o_key_rdy (o_key_rdy),
    .i_key     (i_key),
    .o_key_ok  (o_key_ok),
    .i_ct_vld  (i_ct_vld),
    .o_ct_rdy  (o_ct_rdy),
    .i_ct      (i_ct),
    .o_pt_vld  (o_pt_vld),
    .i_pt_rdy  (i_pt_rdy),
    .o_pt      (o_pt)
  );

  int n_run = 0;
  int n_fail = 0;

  logic [7:0]   m_sb  [256];
  logic [7:0]   m_isb [256];
  logic [127:0] m_rk  [11];

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm,
                      input logic act,
                      input logic exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm,
                      input int act,
                      input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a,
                                       input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from the field inverse plus affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v;
      logic [7:0] s;
      v = '0;
      for (int y = 1; y < 256; y++)
        if (m_mul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      s = 8'h63 ^ v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
          ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]};
      m_sb[x]  = s;
      m_isb[s] = 8'(x);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [127:0] v,
                                         input int i);
    return 8'(v >> (8 * (15 - i)));
  endfunction

  task automatic m_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = 32'(key >> (32 * (3 - i)));
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {m_sb[t[23:16]], m_sb[t[15:8]], m_sb[t[7:0]],
             m_sb[t[31:24]]} ^ {rc, 24'h0};
        rc = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] m_decrypt(input logic [127:0] ct);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = byte_of(ct, 4*c+r) ^ byte_of(m_rk[10], 4*c+r);
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][(c+r)%4] = s[r][c];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = m_isb[t[r][c]] ^ byte_of(m_rk[rnd], 4*c+r);
      if (rnd != 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            t[r][c] = m_mul(8'h0e, s[r][c])
                    ^ m_mul(8'h0b, s[(r+1)%4][c])
                    ^ m_mul(8'h0d, s[(r+2)%4][c])
                    ^ m_mul(8'h09, s[(r+3)%4][c]);
        s = t;
      end
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o = {o[119:0], s[r][c]};
    return o;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat counts the handshake edge as cycle 1
  task automatic load_key(input logic [127:0] key, output int lat);
    i_key     = key;
    i_key_vld = 1'b1;
    for (int b = 0; b < 50 && !o_key_rdy; b++) tick();
    tick();
    i_key_vld = 1'b0;
    lat = 1;
    while (!o_key_ok && lat < 40) begin
      tick();
      lat++;
    end
    m_expand(key);
  endtask

  task automatic start_ct(input logic [127:0] ct);
    i_ct     = ct;
    i_ct_vld = 1'b1;
    for (int b = 0; b < 50 && !o_ct_rdy; b++) tick();
    tick();
    i_ct_vld = 1'b0;
  endtask

  task automatic wait_pt(output int lat);
    lat = 0;
    while (!o_pt_vld && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept_pt();
    i_pt_rdy = 1'b1;
    tick();
    i_pt_rdy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    logic [127:0] k;
    logic [127:0] c;
    logic [127:0] exp;
    logic [127:0] held;
    bit           bad;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3ad77bb40d7a3660a89ecaf32466ef97,
                128'h6bc1bee22e409f96e93d7e117393172a};
    vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'hf5d3d58503b9699de785895a96fdbaaf,
                128'hae2d8a571e03ac9c9eb76fac45af8e51};

    build_sbox();

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    chk1("rst_pt_vld", o_pt_vld, 1'b0);
    chk1("rst_key_ok", o_key_ok, 1'b0);
    chk("rst_pt", o_pt, 128'h0);
    chk1("rst_key_rdy", o_key_rdy, 1'b1);
    chk1("rst_ct_rdy", o_ct_rdy, 1'b0);
    rst = 1'b0;
    tick();

    // known-answer table
    for (int v = 0; v < 4; v++) begin
      load_key(vecs[v].key, lat);
      chki($sformatf("kat%0d_key_lat", v), lat, 11);
      if (v == 0)
        chk("kat0_rk10", dut.rk_q[10],
            128'h13111d7fe3944a17f307a78b4d2b30c5);
      start_ct(vecs[v].ct);
      wait_pt(lat);
      chki($sformatf("kat%0d_pt_lat", v), lat, 10);
      chk($sformatf("kat%0d_pt", v), o_pt, vecs[v].pt);
      accept_pt();
      chk1($sformatf("kat%0d_vld_drop", v), o_pt_vld, 1'b0);
      chk($sformatf("kat%0d_pt_hold", v), o_pt, vecs[v].pt);
    end

    // back-pressure in DONE for 20 cycles
    c   = vecs[1].ct;
    exp = m_decrypt(c);
    start_ct(c);
    wait_pt(lat);
    chki("bp_lat", lat, 10);
    held     = o_pt;
    i_ct     = vecs[2].ct;
    i_ct_vld = 1'b1;
    bad      = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_pt !== held || o_pt_vld !== 1'b1 ||
          o_ct_rdy !== 1'b0 || o_key_rdy !== 1'b0)
        bad = 1'b1;
    end
    chk1("bp_stable", bad, 1'b0);
    chk("bp_pt", held, exp);
    i_ct_vld = 1'b0;
    accept_pt();
    chk1("bp_idle_key_rdy", o_key_rdy, 1'b1);
    chk1("bp_vld_drop", o_pt_vld, 1'b0);

    // key and ct offered together: key wins
    k         = {$urandom, $urandom, $urandom, $urandom};
    i_key     = k;
    i_ct      = vecs[3].ct;
    i_key_vld = 1'b1;
    i_ct_vld  = 1'b1;
    #1;
    chk1("both_ct_rdy", o_ct_rdy, 1'b0);
    chk1("both_key_rdy", o_key_rdy, 1'b1);
    tick();
    i_key_vld = 1'b0;
    i_ct_vld  = 1'b0;
    chk1("both_key_ok_drop", o_key_ok, 1'b0);
    chk1("both_busy", o_key_rdy, 1'b0);
    lat = 1;
    while (!o_key_ok && lat < 40) begin
      tick();
      lat++;
    end
    chki("both_key_lat", lat, 11);
    chk1("both_no_pt", o_pt_vld, 1'b0);
    m_expand(k);
    c = {$urandom, $urandom, $urandom, $urandom};
    start_ct(c);
    wait_pt(lat);
    chk("both_new_key_pt", o_pt, m_decrypt(c));
    accept_pt();

    // random keys and blocks vs model
    for (int kk = 0; kk < 3; kk++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load_key(k, lat);
      chki($sformatf("rnd_k%0d_lat", kk), lat, 11);
      for (int b = 0; b < 5; b++) begin
        c = {$urandom, $urandom, $urandom, $urandom};
        start_ct(c);
        wait_pt(lat);
        chki($sformatf("rnd_k%0d_b%0d_lat", kk, b), lat, 10);
        chk($sformatf("rnd_k%0d_b%0d_pt", kk, b), o_pt, m_decrypt(c));
        if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) tick();
        accept_pt();
      end
    end

    // reset while round r=5 is about to be applied
    start_ct({$urandom, $urandom, $urandom, $urandom});
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk1("mid_rst_pt_vld", o_pt_vld, 1'b0);
    chk1("mid_rst_key_ok", o_key_ok, 1'b0);
    chk1("mid_rst_ct_rdy", o_ct_rdy, 1'b0);
    chk1("mid_rst_idle", o_key_rdy, 1'b1);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (o_pt_vld !== 1'b0 || o_key_ok !== 1'b0) bad = 1'b1;
    end
    chk1("mid_rst_no_output", bad, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
